// File: rtl/overcurrent_guard.sv
// rtl/overcurrent_guard.sv - BCD current sampler with trip/cooldown/retry/lockout motor-enable gate
// Build option: define OCG_BAD_DIGIT_TRIP_EN to count invalid-digit samples as over-current.
module overcurrent_guard #(
  parameter int SAMPLE_DIV   = 10_000_000,
  parameter int TRIP_MV      = 600,
  parameter int CLEAR_MV     = 400,
  parameter int TRIP_COUNT   = 3,
  parameter int COOL_SAMPLES = 20,
  parameter int MAX_RETRIES  = 3
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [11:0] current_value,
  input  logic        motor_en_req,
  input  logic        clear_fault,
  output logic        motor_en,
  output logic        fault,
  output logic        locked,
  output logic [9:0]  current_mv,
  output logic        sample_valid,
  output logic        bad_digit
);

`ifdef OCG_BAD_DIGIT_TRIP_EN
  localparam bit BAD_TRIP_EN = 1'b1;
`else
  localparam bit BAD_TRIP_EN = 1'b0;
`endif

  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int OVER_W = $clog2(TRIP_COUNT + 1);
  localparam int COOL_W = $clog2(COOL_SAMPLES + 1);
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [OVER_W-1:0]  OVER_MAX  = OVER_W'(TRIP_COUNT);
  localparam logic [COOL_W-1:0]  COOL_MAX  = COOL_W'(COOL_SAMPLES);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
  localparam logic [9:0]         TRIP_L    = 10'(TRIP_MV);
  localparam logic [9:0]         CLEAR_L   = 10'(CLEAR_MV);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_TRIPPED = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic               sample_ok;

  logic [3:0]         d_tenths;
  logic [3:0]         d_hundredths;
  logic [3:0]         d_thousandths;
  logic               digits_ok;
  logic [9:0]         decoded_mv;

  state_t             state;
  state_t             state_n;
  logic [OVER_W-1:0]  over_cnt;
  logic [OVER_W-1:0]  over_n;
  logic [COOL_W-1:0]  clear_cnt;
  logic [COOL_W-1:0]  clear_n;
  logic [RETRY_W-1:0] retries;
  logic [RETRY_W-1:0] retries_n;

  logic               eval;
  logic               sample_over;
  logic               sample_clear;

  assign tick = (tick_cnt == TICK_LAST);

  // Free-running sample divider; terminal count is the sample tick
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // BCD digits: [3:0] tenths (x100 mV), [7:4] hundredths (x10 mV), [11:8] thousandths (x1 mV)
  assign d_tenths      = current_value[3:0];
  assign d_hundredths  = current_value[7:4];
  assign d_thousandths = current_value[11:8];
  assign digits_ok     = (d_tenths <= 4'd9) && (d_hundredths <= 4'd9) && (d_thousandths <= 4'd9);

  // 100 = 64 + 32 + 4 and 10 = 8 + 2, so the conversion is a pure shift-add tree
  assign decoded_mv = {d_tenths, 6'b0}
                    + {1'b0, d_tenths, 5'b0}
                    + {4'b0, d_tenths, 2'b0}
                    + {3'b0, d_hundredths, 3'b0}
                    + {5'b0, d_hundredths, 1'b0}
                    + {6'b0, d_thousandths};

  // Capture the decoded reading on the tick; an invalid reading keeps the last good value
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      sample_valid <= 1'b0;
      sample_ok    <= 1'b0;
      current_mv   <= '0;
    end else begin
      sample_valid <= tick;
      if (tick) begin
        sample_ok <= digits_ok;
        if (digits_ok) begin
          current_mv <= decoded_mv;
        end
      end
    end
  end

  // Sticky invalid-digit flag; an operator clear takes priority over a same-cycle bad reading
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      bad_digit <= 1'b0;
    end else if (clear_fault) begin
      bad_digit <= 1'b0;
    end else if (tick && !digits_ok) begin
      bad_digit <= 1'b1;
    end
  end

  // Classify the registered sample; invalid samples only take part when they count as over-current
  assign eval         = sample_valid && (sample_ok || BAD_TRIP_EN);
  assign sample_over  = sample_ok ? (current_mv >= TRIP_L) : 1'b1;
  assign sample_clear = sample_ok && (current_mv < CLEAR_L);

  // Next state, counters and retry budget for the guard
  always_comb begin
    state_n   = state;
    over_n    = over_cnt;
    clear_n   = clear_cnt;
    retries_n = retries;
    if (clear_fault) begin
      retries_n = '0;
      if (state == ST_LOCKOUT) begin
        state_n = ST_RUN;
        over_n  = '0;
        clear_n = '0;
      end
    end else if (eval && (state != ST_LOCKOUT)) begin
      if (sample_over) begin
        over_n = (over_cnt == OVER_MAX) ? over_cnt : over_cnt + 1'b1;
      end else begin
        over_n = '0;
      end
      if (sample_clear) begin
        clear_n = (clear_cnt == COOL_MAX) ? clear_cnt : clear_cnt + 1'b1;
      end else begin
        clear_n = '0;
      end
      case (state)
        ST_RUN: begin
          if (over_n == OVER_MAX) begin
            if (retries == RETRY_MAX) begin
              state_n = ST_LOCKOUT;
            end else begin
              state_n   = ST_TRIPPED;
              retries_n = retries + 1'b1;
            end
            over_n  = '0;
            clear_n = '0;
          end else if (clear_n == COOL_MAX) begin
            retries_n = '0;
          end
        end
        ST_TRIPPED: begin
          if (clear_n == COOL_MAX) begin
            state_n = ST_RUN;
            over_n  = '0;
            clear_n = '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Guard FSM with outputs registered from the next state so they move with it
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      over_cnt  <= '0;
      clear_cnt <= '0;
      retries   <= '0;
      motor_en  <= 1'b0;
      fault     <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_n;
      over_cnt  <= over_n;
      clear_cnt <= clear_n;
      retries   <= retries_n;
      motor_en  <= (state_n == ST_RUN) && motor_en_req;
      fault     <= (state_n != ST_RUN);
      locked    <= (state_n == ST_LOCKOUT);
    end
  end

endmodule

// File: tb/tb_overcurrent_guard.sv
// tb/tb_overcurrent_guard.sv - self-checking bench for overcurrent_guard with a behavioural model
module tb_overcurrent_guard;

  localparam int DIV       = 4;
  localparam int TRIP      = 600;
  localparam int CLR       = 400;
  localparam int TRIP_N    = 3;
  localparam int COOL_N    = 20;
  localparam int RETRY_N   = 3;
  localparam int M_RUN     = 0;
  localparam int M_TRIPPED = 1;
  localparam int M_LOCKED  = 2;
`ifdef OCG_BAD_DIGIT_TRIP_EN
  localparam bit BAD_TRIP = 1'b1;
`else
  localparam bit BAD_TRIP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [11:0] cv;
  logic        req;
  logic        cf;
  logic        motor_en;
  logic        fault;
  logic        locked;
  logic [9:0]  current_mv;
  logic        sample_valid;
  logic        bad_digit;

  int checks = 0;
  int errors = 0;

  // model state
  int m_edges, m_state, m_over, m_clear, m_retries, e_mv;
  bit e_sv, p_ok, e_bad, e_men, e_fault, e_locked;

  overcurrent_guard #(.SAMPLE_DIV(DIV)) dut (
    .CLK100MHZ    (clk),
    .reset        (rst),
    .current_value(cv),
    .motor_en_req (req),
    .clear_fault  (cf),
    .motor_en     (motor_en),
    .fault        (fault),
    .locked       (locked),
    .current_mv   (current_mv),
    .sample_valid (sample_valid),
    .bad_digit    (bad_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs present at that edge
  task automatic model_step();
    int  d_t, d_h, d_m;
    bit  ok, over, clr;
    if (rst) begin
      m_edges = 0; m_state = M_RUN; m_over = 0; m_clear = 0; m_retries = 0;
      e_mv = 0; e_sv = 0; p_ok = 0; e_bad = 0; e_men = 0; e_fault = 0; e_locked = 0;
      return;
    end
    m_edges++;
    // evaluate the sample published on the previous edge
    if (cf) begin
      m_retries = 0;
      if (m_state == M_LOCKED) begin
        m_state = M_RUN; m_over = 0; m_clear = 0;
      end
    end else if (e_sv && (p_ok || BAD_TRIP) && m_state != M_LOCKED) begin
      over = !p_ok || (e_mv >= TRIP);
      clr  = p_ok && (e_mv < CLR);
      m_over  = over ? ((m_over + 1 > TRIP_N) ? TRIP_N : m_over + 1) : 0;
      m_clear = clr ? ((m_clear + 1 > COOL_N) ? COOL_N : m_clear + 1) : 0;
      if (m_state == M_RUN && m_over == TRIP_N) begin
        if (m_retries == RETRY_N) m_state = M_LOCKED;
        else begin
          m_state = M_TRIPPED;
          m_retries++;
        end
        m_over = 0; m_clear = 0;
      end else if (m_state == M_RUN && m_clear == COOL_N) begin
        m_retries = 0;
      end else if (m_state == M_TRIPPED && m_clear == COOL_N) begin
        m_state = M_RUN; m_over = 0; m_clear = 0;
      end
    end
    e_men    = (m_state == M_RUN) && req;
    e_fault  = (m_state != M_RUN);
    e_locked = (m_state == M_LOCKED);
    // sample capture on every DIV-th edge after reset release
    d_t = cv[3:0];
    d_h = cv[7:4];
    d_m = cv[11:8];
    ok  = (d_t < 10) && (d_h < 10) && (d_m < 10);
    e_sv = (m_edges % DIV == 0);
    if (e_sv) begin
      p_ok = ok;
      if (ok) e_mv = d_t * 100 + d_h * 10 + d_m;
    end
    if (cf) e_bad = 0;
    else if (e_sv && !ok) e_bad = 1;
  endtask

  // Model advances on each edge; DUT outputs compared 2 time units later
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #2;
      check("motor_en", motor_en, e_men);
      check("fault", fault, e_fault);
      check("locked", locked, e_locked);
      check("current_mv", current_mv, e_mv);
      check("sample_valid", sample_valid, e_sv);
      check("bad_digit", bad_digit, e_bad);
    end
  end

  task automatic samples(input logic [11:0] val, input int n);
    cv = val;
    repeat (n * DIV) @(negedge clk);
  endtask

  task automatic pulse_clear();
    cf = 1'b1;
    @(negedge clk);
    cf = 1'b0;
    repeat (DIV - 1) @(negedge clk);
  endtask

  function automatic logic [11:0] encode_mv(input int mv);
    logic [11:0] r;
    r[3:0]  = 4'(mv / 100);
    r[7:4]  = 4'((mv / 10) % 10);
    r[11:8] = 4'(mv % 10);
    return r;
  endfunction

  int          hold;
  int          rst_hold;
  int          pick;
  int          nib;
  logic [11:0] rv;

  initial begin
    rst = 1'b1;
    cv  = 12'h524;
    req = 1'b1;
    cf  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset motor_en", motor_en, 0);
    check("reset fault", fault, 0);
    check("reset current_mv", current_mv, 0);
    check("reset bad_digit", bad_digit, 0);
    rst = 1'b0;

    // reset and decode
    samples(12'h524, 3);
    check("decode 0x524", current_mv, 425);
    check("run motor_en", motor_en, 1);
    check("run fault", fault, 0);

    // trip and recover
    samples(12'h076, 4);
    check("trip fault", fault, 1);
    check("trip motor_en", motor_en, 0);
    check("decode 0x076", current_mv, 670);
    samples(12'h001, 21);
    check("recover fault", fault, 0);
    check("recover motor_en", motor_en, 1);

    // hysteresis
    for (int i = 0; i < 10; i++) samples((i % 2 == 0) ? 12'h076 : 12'h005, 1);
    check("hysteresis no trip", fault, 0);

    // lockout after four trips
    pulse_clear();
    for (int i = 0; i < 4; i++) begin
      samples(12'h076, 3);
      if (i < 3) samples(12'h001, 21);
    end
    samples(12'h001, 1);
    check("lockout locked", locked, 1);
    samples(12'h001, 50);
    check("lockout held", locked, 1);
    check("lockout motor_en", motor_en, 0);
    pulse_clear();
    check("unlock locked", locked, 0);
    check("unlock fault", fault, 0);
    check("unlock motor_en", motor_en, 1);

    // invalid digit
    samples(12'h0A0, 4);
    check("bad_digit set", bad_digit, 1);
    check("bad keeps mv", current_mv, 100);
    check("bad trip build", fault, BAD_TRIP);
    cv = 12'h001;
    pulse_clear();
    check("bad_digit cleared", bad_digit, 0);
    samples(12'h001, 21);
    check("bad recover", fault, 0);

    // clear_fault on the third over-current evaluation
    samples(12'h076, 3);
    cv = 12'h001;
    pulse_clear();
    check("contention no trip", fault, 0);
    samples(12'h076, 4);
    check("retrip fault", fault, 1);

    // reset while tripped
    rst = 1'b1;
    #1;
    check("midreset motor_en", motor_en, 0);
    check("midreset fault", fault, 0);
    check("midreset locked", locked, 0);
    check("midreset current_mv", current_mv, 0);
    check("midreset sample_valid", sample_valid, 0);
    check("midreset bad_digit", bad_digit, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // randomized operation
    hold = 0;
    rst_hold = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        hold = $urandom_range(4, 100);
        pick = $urandom_range(0, 99);
        if (pick < 35)      cv = encode_mv($urandom_range(600, 999));
        else if (pick < 50) cv = encode_mv($urandom_range(400, 599));
        else if (pick < 94) cv = encode_mv($urandom_range(0, 399));
        else begin
          rv = 12'($urandom);
          nib = $urandom_range(0, 2);
          rv[nib*4 +: 4] = 4'($urandom_range(10, 15));
          cv = rv;
        end
      end
      hold--;
      if ($urandom_range(0, 19) == 0) req = ~req;
      cf = ($urandom_range(0, 199) == 0);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b0;
      end else if ($urandom_range(0, 2499) == 0) begin
        rst = 1'b1;
        rst_hold = 2;
      end
    end
    @(negedge clk);
    cf = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
